mem_lsu: RTL and testbench

Load/store unit for the MEM stage of the 5-stage RV32I core. Consumes the memory request held in the EX/MEM pipeline register, runs one AXI4-Lite master transaction per load/store, and drives `stall_en` back to the pipeline buffers until the access completes. Returns aligned, sign/zero-extended load data to MEM/WB.

---
 rtl/lsu_pkg.sv | 25 ++
 rtl/lsu_align.sv | 63 ++++++
 rtl/mem_lsu.sv | 200 ++++++++++++++++++++
 tb/tb_mem_lsu.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types and constants for the MEM-stage load/store unit
// Contents:
//   lsu_state_t   : FSM state encoding for mem_lsu
//   LSU_*         : funct3 size/sign encodings for loads and stores
//   AXI_RESP_OKAY : the only non-error AXI response code
package lsu_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        WR      = 3'd3,
        WR_RESP = 3'd4,
        DONE    = 3'd5
    } lsu_state_t;

    localparam logic [2:0] LSU_B  = 3'b000;
    localparam logic [2:0] LSU_H  = 3'b001;
    localparam logic [2:0] LSU_W  = 3'b010;
    localparam logic [2:0] LSU_BU = 3'b100;
    localparam logic [2:0] LSU_HU = 3'b101;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - combinational byte-lane steering for loads and stores
// Ports:
//   funct3        in  3  : access size/sign (LSU_* encodings)
//   offset        in  2  : byte offset within the 32-bit word (addr[1:0])
//   wdata         in  32 : right-aligned store data
//   rdata         in  32 : raw word returned by the bus
//   wstrb         out 4  : byte strobes for the store, shifted into place
//   wdata_shifted out 32 : store data moved to its byte lanes
//   ld_data       out 32 : load data moved down to bit 0 and extended
//   misalign      out 1  : halfword on an odd address or word on a non-zero offset
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata_shifted,
    output logic [31:0] ld_data,
    output logic        misalign
);

    logic [4:0]  bit_off;
    logic [31:0] rshift;

    assign bit_off       = {offset, 3'b000};
    assign wdata_shifted = wdata << bit_off;
    assign rshift        = rdata >> bit_off;

    // Strobes shift with the offset inside a 4-bit field, so lanes that would
    // fall past byte 3 of an unaligned access are simply lost.
    always_comb begin
        wstrb    = 4'b1111 << offset;
        misalign = (offset != 2'b00);
        case (funct3)
            LSU_B, LSU_BU: begin
                wstrb    = 4'b0001 << offset;
                misalign = 1'b0;
            end
            LSU_H, LSU_HU: begin
                wstrb    = 4'b0011 << offset;
                misalign = offset[0];
            end
            default: begin
                wstrb    = 4'b1111 << offset;
                misalign = (offset != 2'b00);
            end
        endcase
    end

    always_comb begin
        ld_data = rshift;
        case (funct3)
            LSU_B:   ld_data = {{24{rshift[7]}}, rshift[7:0]};
            LSU_BU:  ld_data = {24'h000000, rshift[7:0]};
            LSU_H:   ld_data = {{16{rshift[15]}}, rshift[15:0]};
            LSU_HU:  ld_data = {16'h0000, rshift[15:0]};
            default: ld_data = rshift;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// rtl/mem_lsu.sv - MEM-stage load/store unit, one AXI4-Lite transaction per access
// Optional feature macro: MEM_LSU_MISALIGN_EN (trap misaligned halfword/word accesses)
// Ports:
//   ACLK, ARESETn              : clock, synchronous active-low reset
//   req_read, req_write        : load / store request from the EX/MEM buffer
//   req_addr, req_wdata        : byte address, right-aligned store data
//   req_funct3                 : size/sign of the access
//   stall_en                   : hold upstream pipeline buffers
//   ld_data, ld_valid          : extended load result and its one-cycle strobe
//   bus_err                    : one-cycle pulse on a non-OKAY RRESP/BRESP
//   AR*, R*, AW*, W*, B*       : AXI4-Lite master channels
//   misalign                   : (MEM_LSU_MISALIGN_EN only) misaligned access pulse
module mem_lsu
    import lsu_pkg::*;
(
    input  logic        ACLK,
    input  logic        ARESETn,
    input  logic        req_read,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        stall_en,
    output logic [31:0] ld_data,
    output logic        ld_valid,
    output logic        bus_err,
    output logic [31:0] ARADDR,
    output logic        ARVALID,
    input  logic        ARREADY,
    input  logic [31:0] RDATA,
    input  logic [1:0]  RRESP,
    input  logic        RVALID,
    output logic        RREADY,
    output logic [31:0] AWADDR,
    output logic        AWVALID,
    input  logic        AWREADY,
    output logic [31:0] WDATA,
    output logic [3:0]  WSTRB,
    output logic        WVALID,
    input  logic        WREADY,
    input  logic [1:0]  BRESP,
    input  logic        BVALID,
    output logic        BREADY
`ifdef MEM_LSU_MISALIGN_EN
    ,
    output logic        misalign
`endif
);

    lsu_state_t  state;
    logic [2:0]  funct3_q;
    logic [1:0]  offset_q;
    logic        aw_done;
    logic        w_done;

    logic        in_idle;
    logic        req_any;
    logic        aw_fin;
    logic        w_fin;
    logic [2:0]  al_funct3;
    logic [1:0]  al_offset;
    logic [3:0]  al_wstrb;
    logic [31:0] al_wdata;
    logic [31:0] al_ld_data;
    logic        al_misalign;

    assign in_idle = (state == IDLE);
    assign req_any = req_read | req_write;

    // One aligner serves both directions: in IDLE it looks at the incoming
    // request so store lanes can be registered on the way out; afterwards it
    // looks at the latched request so the returning RDATA is extended.
    assign al_funct3 = in_idle ? req_funct3    : funct3_q;
    assign al_offset = in_idle ? req_addr[1:0] : offset_q;

    // Low in DONE so the upstream buffer advances exactly once per access.
    assign stall_en = (in_idle & req_any) | (!in_idle && (state != DONE));

    // A channel counts as finished if it already handshook or does so now,
    // which lets AW and W complete in the same cycle or in either order.
    assign aw_fin = aw_done | (AWVALID & AWREADY);
    assign w_fin  = w_done  | (WVALID & WREADY);

    lsu_align u_align (
        .funct3        (al_funct3),
        .offset        (al_offset),
        .wdata         (req_wdata),
        .rdata         (RDATA),
        .wstrb         (al_wstrb),
        .wdata_shifted (al_wdata),
        .ld_data       (al_ld_data),
        .misalign      (al_misalign)
    );

`ifndef MEM_LSU_MISALIGN_EN
    logic unused_misalign;
    assign unused_misalign = al_misalign;
`endif

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state    <= IDLE;
            funct3_q <= 3'b000;
            offset_q <= 2'b00;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
            ARADDR   <= 32'h0;
            ARVALID  <= 1'b0;
            RREADY   <= 1'b0;
            AWADDR   <= 32'h0;
            AWVALID  <= 1'b0;
            WDATA    <= 32'h0;
            WSTRB    <= 4'h0;
            WVALID   <= 1'b0;
            BREADY   <= 1'b0;
            ld_data  <= 32'h0;
            ld_valid <= 1'b0;
            bus_err  <= 1'b0;
`ifdef MEM_LSU_MISALIGN_EN
            misalign <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    funct3_q <= req_funct3;
                    offset_q <= req_addr[1:0];
                    aw_done  <= 1'b0;
                    w_done   <= 1'b0;
`ifdef MEM_LSU_MISALIGN_EN
                    if (req_any && al_misalign) begin
                        state    <= DONE;
                        misalign <= 1'b1;
                    end else
`endif
                    if (req_read) begin
                        state   <= RD_ADDR;
                        ARADDR  <= {req_addr[31:2], 2'b00};
                        ARVALID <= 1'b1;
                    end else if (req_write) begin
                        state   <= WR;
                        AWADDR  <= {req_addr[31:2], 2'b00};
                        WDATA   <= al_wdata;
                        WSTRB   <= al_wstrb;
                        AWVALID <= 1'b1;
                        WVALID  <= 1'b1;
                    end
                end
                RD_ADDR: begin
                    if (ARREADY) begin
                        ARVALID <= 1'b0;
                        RREADY  <= 1'b1;
                        state   <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (RVALID) begin
                        RREADY   <= 1'b0;
                        ld_data  <= al_ld_data;
                        ld_valid <= 1'b1;
                        bus_err  <= (RRESP != AXI_RESP_OKAY);
                        state    <= DONE;
                    end
                end
                WR: begin
                    if (AWVALID && AWREADY) begin
                        AWVALID <= 1'b0;
                        aw_done <= 1'b1;
                    end
                    if (WVALID && WREADY) begin
                        WVALID <= 1'b0;
                        w_done <= 1'b1;
                    end
                    if (aw_fin && w_fin) begin
                        BREADY <= 1'b1;
                        state  <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (BVALID) begin
                        BREADY  <= 1'b0;
                        bus_err <= (BRESP != AXI_RESP_OKAY);
                        state   <= DONE;
                    end
                end
                DONE: begin
                    ld_valid <= 1'b0;
                    bus_err  <= 1'b0;
`ifdef MEM_LSU_MISALIGN_EN
                    misalign <= 1'b0;
`endif
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// tb/tb_mem_lsu.sv - self-checking bench for mem_lsu with a scripted AXI4-Lite slave
module tb_mem_lsu;

    logic        ACLK = 1'b0;
    logic        ARESETn;
    logic        req_read, req_write;
    logic [31:0] req_addr, req_wdata;
    logic [2:0]  req_funct3;
    logic        stall_en;
    logic [31:0] ld_data;
    logic        ld_valid, bus_err;
    logic [31:0] ARADDR;
    logic        ARVALID, ARREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RVALID, RREADY;
    logic [31:0] AWADDR;
    logic        AWVALID, AWREADY;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WVALID, WREADY;
    logic [1:0]  BRESP;
    logic        BVALID, BREADY;
`ifdef MEM_LSU_MISALIGN_EN
    logic        misalign;
`endif

    always #5 ACLK = ~ACLK;

    mem_lsu dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .req_read(req_read), .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_funct3(req_funct3),
        .stall_en(stall_en), .ld_data(ld_data), .ld_valid(ld_valid), .bus_err(bus_err),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
`ifdef MEM_LSU_MISALIGN_EN
        .misalign(misalign),
`endif
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        bit          rd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  f3;
        logic [31:0] rdata;
        logic [1:0]  resp;
        int          ar_dly, r_dly, aw_dly, w_dly, b_dly;
    } acc_t;

    typedef struct {
        int          stall, done_cyc, ld_cnt, err, mis;
        int          ar_hs, r_hs, aw_hs, w_hs, b_hs, reissue, unstable;
        logic [31:0] ld_data, araddr, awaddr, wdata;
        logic [3:0]  wstrb;
    } obs_t;

    typedef struct {
        acc_t        a;
        logic [31:0] exp_ld;
        logic [3:0]  exp_strb;
        logic [31:0] exp_wdata;
        int          exp_stall;
        int          exp_err;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    function automatic acc_t mk(input bit rd, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [2:0] f3, input logic [31:0] rdata, input logic [1:0] resp,
                                input int ar_dly, input int r_dly, input int aw_dly,
                                input int w_dly, input int b_dly);
        acc_t a;
        a.rd = rd; a.addr = addr; a.wdata = wdata; a.f3 = f3; a.rdata = rdata; a.resp = resp;
        a.ar_dly = ar_dly; a.r_dly = r_dly; a.aw_dly = aw_dly; a.w_dly = w_dly; a.b_dly = b_dly;
        return a;
    endfunction

    function automatic vec_t mkv(input acc_t a, input logic [31:0] ld, input logic [3:0] strb,
                                 input logic [31:0] wd, input int st, input int er);
        vec_t v;
        v.a = a; v.exp_ld = ld; v.exp_strb = strb; v.exp_wdata = wd; v.exp_stall = st; v.exp_err = er;
        return v;
    endfunction

    // ---------------- reference model (byte-lane view of the access) ----------------
    function automatic int nbytes(input logic [2:0] f3);
        return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    endfunction

    function automatic bit is_mis(input acc_t a);
`ifdef MEM_LSU_MISALIGN_EN
        int n;
        n = nbytes(a.f3);
        return (n == 2 && a.addr[0]) || (n == 4 && a.addr[1:0] != 2'b00);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input int off, input logic [31:0] rd);
        logic [31:0] v;
        int n;
        n = nbytes(f3);
        v = 32'h0;
        for (int i = 0; i < n; i++)
            if (off + i < 4) v[8*i +: 8] = rd[8*(off+i) +: 8];
        if (!f3[2] && n < 4 && v[8*n-1])
            for (int i = 8*n; i < 32; i++) v[i] = 1'b1;
        return v;
    endfunction

    function automatic logic [3:0] model_strb(input logic [2:0] f3, input int off);
        logic [3:0] s;
        s = 4'h0;
        for (int i = 0; i < nbytes(f3); i++)
            if (off + i < 4) s[off+i] = 1'b1;
        return s;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [31:0] wd, input int off);
        logic [31:0] w;
        w = 32'h0;
        for (int i = 0; i < 4; i++)
            if (i >= off) w[8*i +: 8] = wd[8*(i-off) +: 8];
        return w;
    endfunction

    // ---------------- one access against a scripted slave ----------------
    task automatic run_access(input acc_t a, output obs_t o);
        int ar_c, r_c, aw_c, w_c, b_c, post, cyc;
        bit r_pend, b_pend, aw_ok, w_ok, done;
        bit ar_wait, aw_wait, w_wait;
        logic [31:0] ar_prev, aw_prev;
        logic [35:0] w_prev;
        o.stall = 0; o.done_cyc = -1; o.ld_cnt = 0; o.err = 0; o.mis = 0;
        o.ar_hs = 0; o.r_hs = 0; o.aw_hs = 0; o.w_hs = 0; o.b_hs = 0;
        o.reissue = 0; o.unstable = 0;
        o.ld_data = 32'h0; o.araddr = 32'h0; o.awaddr = 32'h0; o.wdata = 32'h0; o.wstrb = 4'h0;
        ar_c = 0; r_c = 0; aw_c = 0; w_c = 0; b_c = 0; post = 0;
        r_pend = 0; b_pend = 0; aw_ok = 0; w_ok = 0; done = 0;
        ar_wait = 0; aw_wait = 0; w_wait = 0;
        ar_prev = 32'h0; aw_prev = 32'h0; w_prev = 36'h0;
        @(negedge ACLK);
        req_read = a.rd; req_write = !a.rd; req_addr = a.addr;
        req_wdata = a.wdata; req_funct3 = a.f3;
        for (cyc = 0; cyc < 80 && post < 3; cyc++) begin
            if (done) begin req_read = 1'b0; req_write = 1'b0; end
            ARREADY = ARVALID && (ar_c >= a.ar_dly);
            AWREADY = AWVALID && (aw_c >= a.aw_dly);
            WREADY  = WVALID  && (w_c  >= a.w_dly);
            RVALID  = r_pend && (r_c >= a.r_dly);
            RDATA   = RVALID ? a.rdata : $urandom;
            RRESP   = RVALID ? a.resp : 2'b00;
            BVALID  = b_pend && (b_c >= a.b_dly);
            BRESP   = BVALID ? a.resp : 2'b00;
            #1;
            if (stall_en) o.stall++;
            if (ld_valid) begin o.ld_cnt++; o.ld_data = ld_data; end
            if (bus_err) o.err++;
`ifdef MEM_LSU_MISALIGN_EN
            if (misalign) o.mis++;
`endif
            if (cyc > 0 && !stall_en && !done) begin done = 1; o.done_cyc = cyc; end
            if (done) begin
                post++;
                if (ARVALID || AWVALID || WVALID) o.reissue++;
            end
            if (ARVALID && ar_wait && ARADDR != ar_prev) o.unstable++;
            if (AWVALID && aw_wait && AWADDR != aw_prev) o.unstable++;
            if (WVALID && w_wait && {WSTRB, WDATA} != w_prev) o.unstable++;
            ar_wait = ARVALID && !ARREADY; ar_prev = ARADDR;
            aw_wait = AWVALID && !AWREADY; aw_prev = AWADDR;
            w_wait  = WVALID && !WREADY;   w_prev  = {WSTRB, WDATA};
            if (r_pend) begin
                if (RVALID && RREADY) begin o.r_hs++; r_pend = 0; end
                else r_c++;
            end
            if (ARVALID && ARREADY) begin o.ar_hs++; o.araddr = ARADDR; r_pend = 1; r_c = 0; end
            else if (ARVALID) ar_c++;
            if (b_pend) begin
                if (BVALID && BREADY) begin o.b_hs++; b_pend = 0; end
                else b_c++;
            end
            if (AWVALID && AWREADY) begin o.aw_hs++; o.awaddr = AWADDR; aw_ok = 1; end
            else if (AWVALID) aw_c++;
            if (WVALID && WREADY) begin o.w_hs++; o.wdata = WDATA; o.wstrb = WSTRB; w_ok = 1; end
            else if (WVALID) w_c++;
            if (aw_ok && w_ok) begin b_pend = 1; b_c = 0; aw_ok = 0; w_ok = 0; end
            @(negedge ACLK);
        end
        req_read = 1'b0; req_write = 1'b0;
        ARREADY = 0; AWREADY = 0; WREADY = 0; RVALID = 0; BVALID = 0;
        if (!done) begin
            chk("access_timeout", 32'd0, 32'd1);
            ARESETn = 1'b0;
            @(negedge ACLK);
            ARESETn = 1'b1;
        end
    endtask

    task automatic check_access(input string tag, input acc_t a, input obs_t o);
        int off, exp_stall, mx;
        bit mis, ok_rd, ok_wr;
        off   = int'(a.addr[1:0]);
        mis   = is_mis(a);
        ok_rd = a.rd && !mis;
        ok_wr = !a.rd && !mis;
        mx    = (a.aw_dly > a.w_dly) ? a.aw_dly : a.w_dly;
        if (mis)       exp_stall = 1;
        else if (a.rd) exp_stall = 1 + (a.ar_dly + 1) + (a.r_dly + 1);
        else           exp_stall = 1 + (mx + 1) + (a.b_dly + 1);
        chk({tag, " stall_cycles"}, o.stall, exp_stall);
        chk({tag, " done_cycle"}, o.done_cyc, exp_stall);
        chk({tag, " reissue"}, o.reissue, 0);
        chk({tag, " unstable"}, o.unstable, 0);
        chk({tag, " ld_valid_count"}, o.ld_cnt, ok_rd ? 1 : 0);
        chk({tag, " bus_err_count"}, o.err, (!mis && a.resp != 2'b00) ? 1 : 0);
`ifdef MEM_LSU_MISALIGN_EN
        chk({tag, " misalign_count"}, o.mis, mis ? 1 : 0);
`endif
        chk({tag, " ar_hs"}, o.ar_hs, ok_rd ? 1 : 0);
        chk({tag, " r_hs"}, o.r_hs, ok_rd ? 1 : 0);
        chk({tag, " aw_hs"}, o.aw_hs, ok_wr ? 1 : 0);
        chk({tag, " w_hs"}, o.w_hs, ok_wr ? 1 : 0);
        chk({tag, " b_hs"}, o.b_hs, ok_wr ? 1 : 0);
        if (ok_rd) begin
            chk({tag, " ld_data"}, o.ld_data, model_load(a.f3, off, a.rdata));
            chk({tag, " araddr"}, o.araddr, a.addr & 32'hFFFF_FFFC);
        end
        if (ok_wr) begin
            chk({tag, " awaddr"}, o.awaddr, a.addr & 32'hFFFF_FFFC);
            chk({tag, " wstrb"}, {28'h0, o.wstrb}, {28'h0, model_strb(a.f3, off)});
            chk({tag, " wdata"}, o.wdata, model_wdata(a.wdata, off));
        end
    endtask

    initial begin
        vec_t vecs[8];
        obs_t o;
        acc_t a;
        int   k, extra;
        bit   seen;

        ARESETn = 1'b0;
        req_read = 0; req_write = 0; req_addr = 0; req_wdata = 0; req_funct3 = 0;
        ARREADY = 0; RDATA = 0; RRESP = 0; RVALID = 0;
        AWREADY = 0; WREADY = 0; BRESP = 0; BVALID = 0;
        repeat (3) @(negedge ACLK);
        chk("reset stall_en", stall_en, 0);
        chk("reset ARVALID", ARVALID, 0);
        chk("reset RREADY", RREADY, 0);
        chk("reset AWVALID", AWVALID, 0);
        chk("reset WVALID", WVALID, 0);
        chk("reset BREADY", BREADY, 0);
        chk("reset ld_valid", ld_valid, 0);
        chk("reset bus_err", bus_err, 0);
        chk("reset ld_data", ld_data, 0);
`ifdef MEM_LSU_MISALIGN_EN
        chk("reset misalign", misalign, 0);
`endif
        ARESETn = 1'b1;

        vecs[0] = mkv(mk(1, 32'h1003, 32'h0,      3'b000, 32'h80FF1234, 2'b00, 0, 0, 0, 0, 0),
                      32'hFFFFFF80, 4'h0, 32'h0, 3, 0);
        vecs[1] = mkv(mk(1, 32'h2002, 32'h0,      3'b101, 32'hBEEF0000, 2'b00, 4, 0, 0, 0, 0),
                      32'h0000BEEF, 4'h0, 32'h0, 7, 0);
        vecs[2] = mkv(mk(0, 32'h3001, 32'hAB,     3'b000, 32'h0,        2'b00, 0, 0, 0, 2, 0),
                      32'h0, 4'b0010, 32'h0000AB00, 5, 0);
        vecs[3] = mkv(mk(0, 32'h3000, 32'h12345678, 3'b010, 32'h0,      2'b10, 0, 0, 0, 0, 0),
                      32'h0, 4'b1111, 32'h12345678, 3, 1);
        vecs[4] = mkv(mk(1, 32'h1002, 32'h0,      3'b001, 32'h80010000, 2'b00, 0, 0, 0, 0, 0),
                      32'hFFFF8001, 4'h0, 32'h0, 3, 0);
        vecs[5] = mkv(mk(1, 32'h0000, 32'h0,      3'b100, 32'h000000F0, 2'b00, 0, 2, 0, 0, 0),
                      32'h000000F0, 4'h0, 32'h0, 5, 0);
        vecs[6] = mkv(mk(1, 32'h5000, 32'h0,      3'b010, 32'hDEADBEEF, 2'b11, 0, 0, 0, 0, 0),
                      32'hDEADBEEF, 4'h0, 32'h0, 3, 1);
        vecs[7] = mkv(mk(0, 32'h6002, 32'hCAFE,   3'b001, 32'h0,        2'b00, 0, 0, 3, 0, 1),
                      32'h0, 4'b1100, 32'hCAFE0000, 7, 0);

        for (int i = 0; i < 8; i++) begin
            run_access(vecs[i].a, o);
            chk($sformatf("vec%0d stall", i), o.stall, vecs[i].exp_stall);
            chk($sformatf("vec%0d bus_err", i), o.err, vecs[i].exp_err);
            if (vecs[i].a.rd) begin
                chk($sformatf("vec%0d ld_data", i), o.ld_data, vecs[i].exp_ld);
            end else begin
                chk($sformatf("vec%0d wstrb", i), {28'h0, o.wstrb}, {28'h0, vecs[i].exp_strb});
                chk($sformatf("vec%0d wdata", i), o.wdata, vecs[i].exp_wdata);
            end
            check_access($sformatf("vec%0d", i), vecs[i].a, o);
        end

        // Reset while the read data phase is pending.
        @(negedge ACLK);
        req_read = 1'b1; req_write = 1'b0; req_addr = 32'h7004; req_funct3 = 3'b010;
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            if (RREADY) begin seen = 1; break; end
            ARREADY = ARVALID;
            @(negedge ACLK);
        end
        chk("rst_mid reached RD_DATA", seen, 1);
        ARREADY = 1'b0;
        ARESETn = 1'b0;
        req_read = 1'b0;
        @(negedge ACLK);
        chk("rst_mid RREADY", RREADY, 0);
        chk("rst_mid stall_en", stall_en, 0);
        chk("rst_mid ARVALID", ARVALID, 0);
        chk("rst_mid ld_valid", ld_valid, 0);
        ARESETn = 1'b1;
        extra = 0;
        repeat (3) begin
            @(negedge ACLK);
            if (ARVALID || RREADY || ld_valid || stall_en) extra++;
        end
        chk("rst_mid quiet after release", extra, 0);

`ifdef MEM_LSU_MISALIGN_EN
        a = mk(1, 32'h4002, 32'h0, 3'b010, 32'h11223344, 2'b00, 0, 0, 0, 0, 0);
        run_access(a, o);
        chk("mis_lw ar_hs", o.ar_hs, 0);
        chk("mis_lw misalign", o.mis, 1);
        chk("mis_lw done_cycle", o.done_cyc, 1);
        chk("mis_lw stall", o.stall, 1);
        chk("mis_lw ld_valid", o.ld_cnt, 0);
`endif

        for (int i = 0; i < 40; i++) begin
            a.rd = 1'($urandom_range(0, 1));
            k = $urandom_range(0, 4);
            if (a.rd) a.f3 = (k == 3) ? 3'b100 : (k == 4) ? 3'b101 : 3'(k);
            else      a.f3 = 3'($urandom_range(0, 2));
            a.addr   = $urandom;
            a.wdata  = $urandom;
            a.rdata  = $urandom;
            a.resp   = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            a.ar_dly = $urandom_range(0, 3);
            a.r_dly  = $urandom_range(0, 3);
            a.aw_dly = $urandom_range(0, 3);
            a.w_dly  = $urandom_range(0, 3);
            a.b_dly  = $urandom_range(0, 3);
            run_access(a, o);
            check_access($sformatf("rnd%0d", i), a, o);
        end

        repeat (2) @(negedge ACLK);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
